// File: rtl/dpic_mem_pkg.sv
// dpic_mem_pkg: shared state type, DPI length constants and a counted byte-memory model of pmem_read/pmem_write.
package dpic_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DPI_LEN64 = 8;
  localparam int DPI_LEN32 = 4;
  logic [7:0] mem [logic [63:0]];
  int unsigned rd_calls = 0;
  int unsigned wr_calls = 0;
  function automatic longint pmem_read(input longint raddr, input int len);
    longint r;
    r = 0;
    rd_calls++;
    for (int i = 0; i < 8; i++)
      if (i < len && mem.exists(64'(raddr) + 64'(i)) != 0) r[i*8 +: 8] = mem[64'(raddr) + 64'(i)];
    return r;
  endfunction
  function automatic void pmem_write(input longint waddr, input longint wdata, input byte wmask);
    wr_calls++;
    for (int i = 0; i < 8; i++)
      if (wmask[i]) mem[64'(waddr) + 64'(i)] = wdata[i*8 +: 8];
  endfunction
endpackage

// File: rtl/dpic_mem_range_chk.sv
// dpic_mem_range_chk: combinational check that a full word at addr lies inside [MEM_BASE, MEM_BASE+MEM_SIZE).
module dpic_mem_range_chk #(
   parameter logic [63:0] MEM_BASE = 64'h8000_0000,
   parameter logic [63:0] MEM_SIZE = 64'h0800_0000,
   parameter int          BYTES    = 8
) (
   input  logic [63:0] addr,
   output logic        in_range
);

   // Offset form avoids wrap-around near the top of the 64-bit space.
   assign in_range = (addr >= MEM_BASE) && ((addr - MEM_BASE) <= (MEM_SIZE - 64'(BYTES)));

endmodule

// File: rtl/dpic_mem_port.sv
// dpic_mem_port: valid/ready front end for pmem_read/pmem_write with programmable latency and range errors.
module dpic_mem_port
   import dpic_mem_pkg::*;
#(
   parameter int          ADDR_W   = 64,
   parameter int          DATA_W   = 64,
   parameter int          LATENCY  = 1,
   parameter logic [63:0] MEM_BASE = 64'h8000_0000,
   parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_wmask,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err
);

   localparam int BYTES = DATA_W / 8;
   localparam int LEN   = (DATA_W == 64) ? DPI_LEN64 : DPI_LEN32;

`ifndef SYNTHESIS
   if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("dpic_mem_port: DATA_W must be 32 or 64");
   end
   if (LATENCY < 0 || LATENCY > 255) begin : g_bad_latency
      $error("dpic_mem_port: LATENCY must be in 0..255");
   end
`endif

   state_t              state, state_nx;
   logic [7:0]          cnt;
   logic                wr_q;
   logic [63:0]         addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BYTES-1:0]    wmask_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic [63:0]         req_addr64;
   logic                accept, do_acc, in_range;
   logic                acc_wr;
   logic [63:0]         acc_addr;
   logic [DATA_W-1:0]   acc_wdata;
   logic [BYTES-1:0]    acc_wmask;

   assign req_addr64 = 64'(req_addr) & ~64'(BYTES - 1);
   assign accept     = req_valid && req_ready;
   // With zero latency the access uses the live request fields on the accept edge.
   assign do_acc     = (state == WAIT && cnt == 8'd1) || (accept && LATENCY == 0);
   assign acc_wr     = (state == IDLE) ? req_write  : wr_q;
   assign acc_addr   = (state == IDLE) ? req_addr64 : addr_q;
   assign acc_wdata  = (state == IDLE) ? req_wdata  : wdata_q;
   assign acc_wmask  = (state == IDLE) ? req_wmask  : wmask_q;

   dpic_mem_range_chk #(
      .MEM_BASE (MEM_BASE),
      .MEM_SIZE (MEM_SIZE),
      .BYTES    (BYTES)
   ) u_range (
      .addr     (acc_addr),
      .in_range (in_range)
   );

   always_comb begin
      state_nx   = state;
      req_ready  = reset && state == IDLE;
      resp_valid = state == RESP;
      if (accept) state_nx = (LATENCY == 0) ? RESP : WAIT;
      if (state == WAIT && cnt == 8'd1) state_nx = RESP;
      if (state == RESP && resp_ready) state_nx = IDLE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr64;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            cnt     <= 8'(LATENCY);
         end
         if (state == WAIT) cnt <= cnt - 8'd1;
         if (do_acc) begin
            err_q <= !in_range;
            if (!in_range) rdata_q <= '0;
            else if (acc_wr) begin
               pmem_write(acc_addr, 64'(acc_wdata), 8'(acc_wmask));
               rdata_q <= '0;
            end else rdata_q <= DATA_W'(pmem_read(acc_addr, LEN));
         end
         if (state == RESP && resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dpic_mem_port.sv
// tb_dpic_mem_port: directed checks of dpic_mem_port at latencies 0, 1, 5 and 4 sharing one memory model.
module tb_dpic_mem_port;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_write = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wmask = '0;
   logic [3:0]  rv = '0;
   logic [3:0]  rr = 4'hf;
   logic [3:0]  qr, pv;
   logic [63:0] rd [4];
   logic        er [4];
   int          tests = 0;
   int          fails = 0;

   always #5 clock = ~clock;

   // index 0: LATENCY 0, 1: LATENCY 1, 2: LATENCY 5, 3: LATENCY 4
   dpic_mem_port #(.LATENCY(0)) u_l0 (.clock(clock), .reset(reset), .req_valid(rv[0]), .req_ready(qr[0]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(pv[0]), .resp_ready(rr[0]), .resp_rdata(rd[0]), .resp_err(er[0]));
   dpic_mem_port #(.LATENCY(1)) u_l1 (.clock(clock), .reset(reset), .req_valid(rv[1]), .req_ready(qr[1]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(pv[1]), .resp_ready(rr[1]), .resp_rdata(rd[1]), .resp_err(er[1]));
   dpic_mem_port #(.LATENCY(5)) u_l5 (.clock(clock), .reset(reset), .req_valid(rv[2]), .req_ready(qr[2]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(pv[2]), .resp_ready(rr[2]), .resp_rdata(rd[2]), .resp_err(er[2]));
   dpic_mem_port #(.LATENCY(4)) u_l4 (.clock(clock), .reset(reset), .req_valid(rv[3]), .req_ready(qr[3]),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(pv[3]), .resp_ready(rr[3]), .resp_rdata(rd[3]), .resp_err(er[3]));

   // lat counts falling edges after the accept edge up to the first one with resp_valid high.
   task automatic do_req(input int k, input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] m, input logic hold, output logic [63:0] rdata,
                         output logic err, output int lat, output logic rdy_seen, output logic post_v);
      @(negedge clock);
      req_write = w; req_addr = a; req_wdata = d; req_wmask = m; rv[k] = 1'b1;
      @(posedge clock);
      #1 rv[k] = 1'b0;
      lat = 0;
      rdy_seen = 1'b0;
      do begin
         @(negedge clock);
         lat++;
         rdy_seen = rdy_seen | qr[k];
      end while (!pv[k] && lat < 50);
      rdata = rd[k];
      err = er[k];
      post_v = 1'b1;
      if (!hold) begin
         @(negedge clock);
         post_v = pv[k];
      end
   endtask

   task automatic test_reset;
      #12;
      tests++; if (qr !== 4'h0) begin fails++; $display("FAIL reset_req_ready got %b exp 0000", qr); end
      tests++; if (pv !== 4'h0) begin fails++; $display("FAIL reset_resp_valid got %b exp 0000", pv); end
      tests++; if (rd[1] !== 64'h0 || er[1] !== 1'b0) begin fails++; $display("FAIL reset_resp got %h/%b exp 0/0", rd[1], er[1]); end
      @(negedge clock); reset = 1'b1;
      @(negedge clock);
      tests++; if (qr !== 4'hf) begin fails++; $display("FAIL post_reset_ready got %b exp 1111", qr); end
      tests++; if (dpic_mem_pkg::rd_calls + dpic_mem_pkg::wr_calls !== 0) begin fails++; $display("FAIL reset_calls got %0d exp 0", dpic_mem_pkg::rd_calls + dpic_mem_pkg::wr_calls); end
   endtask

   task automatic test_read_lat1;
      logic [63:0] r; logic e, rs, pvv; int lat;
      do_req(1, 1'b1, 64'h8000_0000, 64'h1122_3344_5566_7788, 8'hff, 1'b0, r, e, lat, rs, pvv);
      tests++; if (r !== 64'h0 || e !== 1'b0) begin fails++; $display("FAIL wr_resp got %h/%b exp 0/0", r, e); end
      do_req(1, 1'b0, 64'h8000_0000, 64'h0, 8'h0, 1'b0, r, e, lat, rs, pvv);
      tests++; if (r !== 64'h1122_3344_5566_7788) begin fails++; $display("FAIL rd_lat1 got %h exp 1122334455667788", r); end
      tests++; if (e !== 1'b0) begin fails++; $display("FAIL rd_lat1_err got %b exp 0", e); end
      tests++; if (lat !== 2) begin fails++; $display("FAIL rd_lat1_latency got %0d exp 2", lat); end
      tests++; if (pvv !== 1'b0 || qr[1] !== 1'b1) begin fails++; $display("FAIL rd_lat1_handshake got v=%b rdy=%b exp 0/1", pvv, qr[1]); end
   endtask

   task automatic test_masked_write;
      logic [63:0] r; logic e, rs, pvv; int lat; int unsigned wc;
      do_req(1, 1'b1, 64'h8000_0008, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0f, 1'b0, r, e, lat, rs, pvv);
      do_req(1, 1'b0, 64'h8000_0008, 64'h0, 8'h0, 1'b0, r, e, lat, rs, pvv);
      tests++; if (r !== 64'h0000_0000_CCCC_DDDD) begin fails++; $display("FAIL mask_wr got %h exp 00000000ccccdddd", r); end
      wc = dpic_mem_pkg::wr_calls;
      do_req(1, 1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0, r, e, lat, rs, pvv);
      tests++; if (dpic_mem_pkg::wr_calls !== wc + 1 || e !== 1'b0) begin fails++; $display("FAIL zero_mask got calls=%0d err=%b exp %0d/0", dpic_mem_pkg::wr_calls, e, wc + 1); end
      do_req(1, 1'b0, 64'h8000_000B, 64'h0, 8'h0, 1'b0, r, e, lat, rs, pvv);
      tests++; if (r !== 64'h0000_0000_CCCC_DDDD) begin fails++; $display("FAIL unaligned_rd got %h exp 00000000ccccdddd", r); end
   endtask

   task automatic test_latency;
      logic [63:0] r; logic e, rs, pvv; int lat;
      do_req(0, 1'b0, 64'h8000_0000, 64'h0, 8'h0, 1'b0, r, e, lat, rs, pvv);
      tests++; if (lat !== 1 || r !== 64'h1122_3344_5566_7788) begin fails++; $display("FAIL lat0 got lat=%0d data=%h exp 1/1122334455667788", lat, r); end
      do_req(2, 1'b0, 64'h8000_0000, 64'h0, 8'h0, 1'b0, r, e, lat, rs, pvv);
      tests++; if (lat !== 6 || r !== 64'h1122_3344_5566_7788) begin fails++; $display("FAIL lat5 got lat=%0d data=%h exp 6/1122334455667788", lat, r); end
      tests++; if (rs !== 1'b0) begin fails++; $display("FAIL lat5_ready got %b exp 0", rs); end
   endtask

   task automatic test_range;
      logic [63:0] r; logic e, rs, pvv; int lat; int unsigned rc;
      rc = dpic_mem_pkg::rd_calls;
      do_req(1, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h0, 1'b0, r, e, lat, rs, pvv);
      tests++; if (e !== 1'b1 || r !== 64'h0) begin fails++; $display("FAIL below_base got %h/%b exp 0/1", r, e); end
      do_req(1, 1'b0, 64'h8800_0000, 64'h0, 8'h0, 1'b0, r, e, lat, rs, pvv);
      tests++; if (e !== 1'b1 || r !== 64'h0) begin fails++; $display("FAIL above_top got %h/%b exp 0/1", r, e); end
      tests++; if (dpic_mem_pkg::rd_calls !== rc) begin fails++; $display("FAIL err_calls got %0d exp %0d", dpic_mem_pkg::rd_calls, rc); end
      do_req(1, 1'b0, 64'h87FF_FFF8, 64'h0, 8'h0, 1'b0, r, e, lat, rs, pvv);
      tests++; if (e !== 1'b0 || dpic_mem_pkg::rd_calls !== rc + 1) begin fails++; $display("FAIL last_word got err=%b calls=%0d exp 0/%0d", e, dpic_mem_pkg::rd_calls, rc + 1); end
      do_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 8'hff, 1'b0, r, e, lat, rs, pvv);
      tests++; if (e !== 1'b1) begin fails++; $display("FAIL top_of_space got %b exp 1", e); end
   endtask

   task automatic test_backpressure;
      logic [63:0] r; logic e, rs, pvv; int lat; int unsigned rc; logic stable, rdy_any;
      rc = dpic_mem_pkg::rd_calls;
      rr[1] = 1'b0;
      do_req(1, 1'b0, 64'h8000_0000, 64'h0, 8'h0, 1'b1, r, e, lat, rs, pvv);
      rv[1] = 1'b1;
      stable = 1'b1; rdy_any = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         stable = stable & (rd[1] === 64'h1122_3344_5566_7788) & (pv[1] === 1'b1);
         rdy_any = rdy_any | qr[1];
      end
      tests++; if (stable !== 1'b1) begin fails++; $display("FAIL bp_stable got %b exp 1", stable); end
      tests++; if (rdy_any !== 1'b0) begin fails++; $display("FAIL bp_ready got %b exp 0", rdy_any); end
      tests++; if (dpic_mem_pkg::rd_calls !== rc + 1) begin fails++; $display("FAIL bp_calls got %0d exp %0d", dpic_mem_pkg::rd_calls, rc + 1); end
      rv[1] = 1'b0; rr[1] = 1'b1;
      @(negedge clock);
      tests++; if (pv[1] !== 1'b0 || rd[1] !== 64'h0) begin fails++; $display("FAIL bp_release got v=%b d=%h exp 0/0", pv[1], rd[1]); end
   endtask

   task automatic test_reset_mid;
      logic [63:0] r; logic e, rs, pvv; int lat; int unsigned wc;
      wc = dpic_mem_pkg::wr_calls;
      @(negedge clock);
      req_write = 1'b1; req_addr = 64'h8000_0000; req_wdata = 64'hDEAD_BEEF_DEAD_BEEF; req_wmask = 8'hff; rv[3] = 1'b1;
      @(posedge clock);
      #1 rv[3] = 1'b0;
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
      #1;
      tests++; if (pv[3] !== 1'b0 || qr[3] !== 1'b0) begin fails++; $display("FAIL mid_reset got v=%b rdy=%b exp 0/0", pv[3], qr[3]); end
      repeat (6) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      tests++; if (dpic_mem_pkg::wr_calls !== wc) begin fails++; $display("FAIL mid_reset_calls got %0d exp %0d", dpic_mem_pkg::wr_calls, wc); end
      do_req(3, 1'b0, 64'h8000_0000, 64'h0, 8'h0, 1'b0, r, e, lat, rs, pvv);
      tests++; if (r !== 64'h1122_3344_5566_7788 || lat !== 5) begin fails++; $display("FAIL mid_reset_rd got %h lat=%0d exp 1122334455667788/5", r, lat); end
   endtask

   initial begin
      test_reset();
      test_read_lat1();
      test_masked_write();
      test_latency();
      test_range();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
